// File: rtl/note_recorder.sv
// note_recorder: samples the four live voice frequency codes once per step
// and writes them as {freq1,freq2,freq3,freq4} words to consecutive note
// memory addresses. A take is closed with END_MARK, so a dumped memory image
// replays through the playback controller unchanged.
module note_recorder #(
  parameter int          STEP_CYCLES = 50000,
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] END_MARK    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record_en,
  input  logic [7:0]        freq1,
  input  logic [7:0]        freq2,
  input  logic [7:0]        freq3,
  input  logic [7:0]        freq4,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W-1:0] note_count
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   note_count_q, note_count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                recording_q, recording_d;
  logic                done_q, done_d;

  // Next-state and write decision; a falling record_en outranks a step end,
  // and a full memory turns the step-end write into the closing marker.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    note_count_d = note_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (record_en) begin
          state_d      = REC;
          step_cnt_d   = '0;
          wr_ptr_d     = '0;
          note_count_d = '0;
        end
      end

      REC: begin
        step_cnt_d = step_cnt_q + CNT_ONE;
        if (!record_en) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = END_MARK;
          state_d     = DONE;
        end else if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          if (wr_ptr_q == PTR_LAST) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = PTR_LAST;
            mem_wdata_d = END_MARK;
            state_d     = DONE;
          end else begin
            mem_we_d     = 1'b1;
            mem_addr_d   = wr_ptr_q;
            mem_wdata_d  = {freq1, freq2, freq3, freq4};
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            note_count_d = note_count_q + PTR_ONE;
          end
        end
      end

      DONE: begin
        if (!record_en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    recording_d = (state_d == REC);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      step_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      note_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      recording_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      note_count_q <= note_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      recording_q  <= recording_d;
      done_q       <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign recording  = recording_q;
  assign done       = done_q;
  assign note_count = note_count_q;

endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed takes against note_recorder with STEP_CYCLES=4
// and DEPTH=4. Every write strobe is logged with its cycle number relative
// to the edge that entered REC, then compared with hand-computed values.
module tb_note_recorder;

  localparam int ADDR_W = 8;
  localparam int LOG_MAX = 16;

  logic              clk;
  logic              reset;
  logic              record_en;
  logic [7:0]        freq1, freq2, freq3, freq4;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              recording;
  logic              done;
  logic [ADDR_W-1:0] note_count;

  int          vectorCount;
  int          miscompareCount;
  int          cycleCnt;
  int          logN;
  int          logCycle [LOG_MAX];
  logic [31:0] logAddr  [LOG_MAX];
  logic [31:0] logData  [LOG_MAX];

  note_recorder #(
    .STEP_CYCLES(4),
    .ADDR_W     (ADDR_W),
    .DEPTH      (4),
    .END_MARK   (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .record_en (record_en),
    .freq1     (freq1),
    .freq2     (freq2),
    .freq3     (freq3),
    .freq4     (freq4),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .recording (recording),
    .done      (done),
    .note_count(note_count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Empties the write log; the next edge becomes cycle 0.
  task automatic clearLog();
    logN = 0;
    cycleCnt = -1;
    for (int i = 0; i < LOG_MAX; i++) begin
      logCycle[i] = -1;
      logAddr[i]  = 32'hDEAD_DEAD;
      logData[i]  = 32'hDEAD_DEAD;
    end
  endtask

  // Drives inputs on the falling edge, runs n rising edges and logs every
  // write strobe seen on the following falling edge.
  task automatic applyStimulus(input logic rst, input logic rec,
                               input logic [31:0] freqs, input int n);
    reset     = rst;
    record_en = rec;
    {freq1, freq2, freq3, freq4} = freqs;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cycleCnt++;
      @(negedge clk);
      if (mem_we) begin
        if (logN < LOG_MAX) begin
          logCycle[logN] = cycleCnt;
          logAddr[logN]  = 32'(mem_addr);
          logData[logN]  = mem_wdata;
        end
        logN++;
      end
    end
  endtask

  // Compares one logged write against its expected cycle, address and data.
  task automatic checkWrite(input string tag, input int idx, input int cyc,
                            input logic [31:0] addr, input logic [31:0] data);
    checkOutput({tag, ".cycle"}, 32'(logCycle[idx]), 32'(cyc));
    checkOutput({tag, ".addr"},  logAddr[idx], addr);
    checkOutput({tag, ".data"},  logData[idx], data);
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    reset     = 1'b1;
    record_en = 1'b0;
    {freq1, freq2, freq3, freq4} = 32'h0;
    clearLog();
    @(negedge clk);

    // Reset state.
    applyStimulus(1'b1, 1'b0, 32'h0, 2);
    checkOutput("rst.mem_we",     32'(mem_we), 32'd0);
    checkOutput("rst.mem_addr",   32'(mem_addr), 32'd0);
    checkOutput("rst.mem_wdata",  mem_wdata, 32'd0);
    checkOutput("rst.recording",  32'(recording), 32'd0);
    checkOutput("rst.done",       32'(done), 32'd0);
    checkOutput("rst.note_count", 32'(note_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2);

    // Take runs until the memory fills: three notes and a marker at addr 3.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h1122_3344, 1);
    checkOutput("full.recording", 32'(recording), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h1122_3344, 16);
    checkOutput("full.writes", 32'(logN), 32'd4);
    checkWrite("full.w0", 0, 4,  32'd0, 32'h1122_3344);
    checkWrite("full.w1", 1, 8,  32'd1, 32'h1122_3344);
    checkWrite("full.w2", 2, 12, 32'd2, 32'h1122_3344);
    checkWrite("full.w3", 3, 16, 32'd3, 32'hFFFF_FFFF);
    checkOutput("full.done",       32'(done), 32'd1);
    checkOutput("full.recording2", 32'(recording), 32'd0);
    checkOutput("full.note_count", 32'(note_count), 32'd3);

    // record_en held high after the take closes: no restart, no writes.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h1122_3344, 8);
    checkOutput("hold.writes", 32'(logN), 32'd0);
    checkOutput("hold.done",   32'(done), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h1122_3344, 1);
    checkOutput("hold.idle_done",  32'(done), 32'd0);
    checkOutput("hold.idle_rec",   32'(recording), 32'd0);
    checkOutput("hold.idle_count", 32'(note_count), 32'd3);

    // Fresh take with a frequency change, stopped mid-step.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h1122_3344, 1);
    checkOutput("stop.recording",  32'(recording), 32'd1);
    checkOutput("stop.count_zero", 32'(note_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h1122_3344, 5);
    applyStimulus(1'b0, 1'b1, 32'h0102_0304, 4);
    applyStimulus(1'b0, 1'b0, 32'h0102_0304, 1);
    checkOutput("stop.writes", 32'(logN), 32'd3);
    checkWrite("stop.w0", 0, 4,  32'd0, 32'h1122_3344);
    checkWrite("stop.w1", 1, 8,  32'd1, 32'h0102_0304);
    checkWrite("stop.w2", 2, 10, 32'd2, 32'hFFFF_FFFF);
    checkOutput("stop.note_count", 32'(note_count), 32'd2);
    checkOutput("stop.done",       32'(done), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);

    // Stop lands exactly on a step-end edge: the marker replaces the note.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'hFF00_FF00, 8);
    applyStimulus(1'b0, 1'b0, 32'hFF00_FF00, 1);
    checkOutput("edge.writes", 32'(logN), 32'd2);
    checkWrite("edge.w0", 0, 4, 32'd0, 32'hFF00_FF00);
    checkWrite("edge.w1", 1, 8, 32'd1, 32'hFFFF_FFFF);
    checkOutput("edge.note_count", 32'(note_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);

    // Stop before the first step completes: marker alone at addr 0.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h00FF_807F, 2);
    applyStimulus(1'b0, 1'b0, 32'h00FF_807F, 1);
    checkOutput("early.writes", 32'(logN), 32'd1);
    checkWrite("early.w0", 0, 2, 32'd0, 32'hFFFF_FFFF);
    checkOutput("early.note_count", 32'(note_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);

    // Reset on a step-end edge: the pending note write is dropped.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h00FF_807F, 4);
    applyStimulus(1'b1, 1'b1, 32'h00FF_807F, 1);
    checkOutput("mrst.writes",     32'(logN), 32'd0);
    checkOutput("mrst.mem_we",     32'(mem_we), 32'd0);
    checkOutput("mrst.mem_addr",   32'(mem_addr), 32'd0);
    checkOutput("mrst.mem_wdata",  mem_wdata, 32'd0);
    checkOutput("mrst.recording",  32'(recording), 32'd0);
    checkOutput("mrst.done",       32'(done), 32'd0);
    checkOutput("mrst.note_count", 32'(note_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2);

    // Verbatim storage of extreme codes, including a silent voice.
    clearLog();
    applyStimulus(1'b0, 1'b1, 32'h00FF_807F, 5);
    checkOutput("code.writes", 32'(logN), 32'd1);
    checkWrite("code.w0", 0, 4, 32'd0, 32'h00FF_807F);
    checkOutput("code.note_count", 32'(note_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
